// File: rtl/pak_dsp_pkg.sv
// Shared types and default constants for the pak_dsp configuration master.
// Holds the FSM state enum and the default coefficient map / control word.
package pak_dsp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CTRL,
        READBACK,
        FINISH
    } cfg_state_t;

    localparam int DEF_NUM_COEFF  = 16;
    localparam int DEF_COEFF_BASE = 31;
    localparam int DEF_CTRL_ADDR  = 0;
    localparam int DEF_CTRL_VALUE = 64;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pak_dsp_xor_acc.sv
// XOR checksum accumulator: clear has priority over enable, one word per cycle.
module pak_dsp_xor_acc #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] sum_reg;

    // One toggle-style bit slice per data bit.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        // Bit gi accumulates the parity of every enabled din[gi].
        always_ff @(posedge clk) begin
            if (!arst_n) begin
                sum_reg[gi] <= 1'b0;
            end else if (clr) begin
                sum_reg[gi] <= 1'b0;
            end else if (en) begin
                sum_reg[gi] <= sum_reg[gi] ^ din[gi];
            end
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/pak_dsp_cfg_master.sv
// Configuration master for pak_dsp: streams NUM_COEFF coefficient words into
// consecutive registers starting at COEFF_BASE, then writes the enable word
// to the control register and pulses done.
// Optional build macro PAK_DSP_CFG_READBACK_EN adds a readback pass that
// compares the XOR of the read words against the XOR of the written words.
module pak_dsp_cfg_master
    import pak_dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_COEFF  = DEF_NUM_COEFF,
    parameter int COEFF_BASE = DEF_COEFF_BASE,
    parameter int CTRL_ADDR  = DEF_CTRL_ADDR,
    parameter int CTRL_VALUE = DEF_CTRL_VALUE
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data_in,
    input  logic                  cfg_valid_in,
    output logic                  cfg_ready_out,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int              CW        = cnt_width(NUM_COEFF);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(NUM_COEFF);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(COEFF_BASE);
    localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(CTRL_ADDR);
    localparam logic [DATA_WIDTH-1:0] CTRL_D = DATA_WIDTH'(CTRL_VALUE);

    cfg_state_t            state_reg, state_next;
    logic [CW-1:0]         acc_cnt_reg, acc_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  write_en_reg, write_en_next;
    logic                  sum_clr;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] wr_sum;

`ifdef PAK_DSP_CFG_READBACK_EN
    logic [CW-1:0]         rb_cnt_reg, rb_cnt_next;
    logic                  err_reg, err_next;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_sum;
`endif

    // Ready only while the load still needs words; counter stops at NUM_COEFF.
    assign cfg_ready_out = (state_reg == LOAD) && (acc_cnt_reg != LAST_CNT);
    assign handshake     = cfg_valid_in & cfg_ready_out;

    // Checksum of every coefficient word accepted (each one is written next cycle).
    pak_dsp_xor_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_acc (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (sum_clr),
        .en     (handshake),
        .din    (cfg_data_in),
        .sum    (wr_sum)
    );

`ifdef PAK_DSP_CFG_READBACK_EN
    // Checksum of the words returned during readback.
    pak_dsp_xor_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_acc (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (sum_clr),
        .en     (rd_en),
        .din    (rdata),
        .sum    (rd_sum)
    );
`else
    // Without readback nothing consumes the read port or the write checksum.
    logic unused_sig;
    assign unused_sig = ^{rdata, wr_sum};
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_next    = state_reg;
        acc_cnt_next  = acc_cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        write_en_next = 1'b0;
        sum_clr       = 1'b0;
`ifdef PAK_DSP_CFG_READBACK_EN
        rb_cnt_next   = rb_cnt_reg;
        err_next      = err_reg;
        rd_en         = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD;
                    acc_cnt_next = '0;
                    sum_clr      = 1'b1;
`ifdef PAK_DSP_CFG_READBACK_EN
                    err_next     = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (handshake) begin
                    write_en_next = 1'b1;
                    addr_next     = BASE_A + ADDR_WIDTH'(acc_cnt_reg);
                    wdata_next    = cfg_data_in;
                    acc_cnt_next  = acc_cnt_reg + 1'b1;
                end else if (acc_cnt_reg == LAST_CNT) begin
                    // Last coefficient is on the bus this cycle; control write follows.
                    state_next    = CTRL;
                    write_en_next = 1'b1;
                    addr_next     = CTRL_A;
                    wdata_next    = CTRL_D;
                end
            end
            CTRL: begin
`ifdef PAK_DSP_CFG_READBACK_EN
                state_next  = READBACK;
                rb_cnt_next = '0;
                addr_next   = BASE_A;
`else
                state_next  = FINISH;
`endif
            end
            READBACK: begin
`ifdef PAK_DSP_CFG_READBACK_EN
                // rdata lags the address by one cycle, so cycle 0 carries nothing.
                rd_en = (rb_cnt_reg != '0);
                if (rb_cnt_reg == LAST_CNT) begin
                    state_next = FINISH;
                    err_next   = ((rd_sum ^ rdata) != wr_sum);
                end else begin
                    rb_cnt_next = rb_cnt_reg + 1'b1;
                    if (rb_cnt_reg != LAST_CNT - 1'b1) begin
                        addr_next = BASE_A + ADDR_WIDTH'(rb_cnt_reg + 1'b1);
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: counters and the register-bus outputs.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            acc_cnt_reg  <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            write_en_reg <= 1'b0;
`ifdef PAK_DSP_CFG_READBACK_EN
            rb_cnt_reg   <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            acc_cnt_reg  <= acc_cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            write_en_reg <= write_en_next;
`ifdef PAK_DSP_CFG_READBACK_EN
            rb_cnt_reg   <= rb_cnt_next;
            err_reg      <= err_next;
`endif
        end
    end

    assign addr     = addr_reg;
    assign wdata    = wdata_reg;
    assign write_en = write_en_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FINISH);
`ifdef PAK_DSP_CFG_READBACK_EN
    assign err      = err_reg;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_pak_dsp_cfg_master.sv
// Self-checking bench for pak_dsp_cfg_master: scenario table plus a
// cycle-level reference model built from the load/readback rules.
`timescale 1ns/1ps
module tb_pak_dsp_cfg_master;

    localparam int DW       = 16;
    localparam int AW       = 6;
    localparam int N        = 16;
    localparam int BASE     = 31;
    localparam int CADDR    = 0;
    localparam int CVAL     = 64;
    localparam int BAD_ADDR = 40;
`ifdef PAK_DSP_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n, start, cfg_valid_in, cfg_ready_out;
    logic          write_en, busy, done, err;
    logic [DW-1:0] cfg_data_in, wdata, rdata;
    logic [AW-1:0] addr;

    always #5 clk = ~clk;

    pak_dsp_cfg_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_COEFF  (N),
        .COEFF_BASE (BASE),
        .CTRL_ADDR  (CADDR),
        .CTRL_VALUE (CVAL)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .start         (start),
        .cfg_data_in   (cfg_data_in),
        .cfg_valid_in  (cfg_valid_in),
        .cfg_ready_out (cfg_ready_out),
        .addr          (addr),
        .write_en      (write_en),
        .wdata         (wdata),
        .rdata         (rdata),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // pak_dsp register file: registered read, optional corruption of one address.
    logic [DW-1:0] pmem [0:63];
    bit            corrupt;
    always @(posedge clk) begin
        if (write_en) pmem[addr] <= wdata;
        rdata <= (corrupt && addr == AW'(BAD_ADDR)) ? 16'hFFFF : pmem[addr];
    end

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_CTRL, M_RB, M_FIN} mphase_t;
    mphase_t       m_phase = M_IDLE;
    int            m_acc = 0;
    int            m_rb = 0;
    bit            m_err = 1'b0;
    bit            m_fin_seen = 1'b0;
    logic [DW-1:0] m_wxor = '0;
    logic [DW-1:0] m_mem [0:63];
    bit            e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;

    int errors = 0;
    int checks = 0;
    int mon_coeff, mon_ctrl, mon_done;
    logic mon_err;

    function automatic logic [DW-1:0] exp_read_xor();
        logic [DW-1:0] x = '0;
        for (int k = 0; k < N; k++) begin
            int a = (BASE + k) % 64;
            x ^= (corrupt && a == BAD_ADDR) ? 16'hFFFF : m_mem[a];
        end
        return x;
    endfunction

    task automatic model_update();
        m_fin_seen = 1'b0;
        if (!arst_n) begin
            m_phase = M_IDLE; m_acc = 0; m_rb = 0; m_err = 1'b0; m_wxor = '0;
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    e_we = 1'b0;
                    if (start) begin
                        m_phase = M_LOAD; m_acc = 0; m_err = 1'b0; m_wxor = '0;
                    end
                end
                M_LOAD: begin
                    e_we = 1'b0;
                    if (m_acc == N) begin
                        m_phase = M_CTRL; e_we = 1'b1;
                        e_addr = AW'(CADDR); e_wdata = DW'(CVAL);
                    end else if (cfg_valid_in) begin
                        e_we = 1'b1;
                        e_addr = AW'((BASE + m_acc) % 64);
                        e_wdata = cfg_data_in;
                        m_mem[(BASE + m_acc) % 64] = cfg_data_in;
                        m_wxor ^= cfg_data_in;
                        m_acc++;
                    end
                end
                M_CTRL: begin
                    e_we = 1'b0;
                    if (RB) begin
                        m_phase = M_RB; m_rb = 0; e_addr = AW'(BASE);
                    end else begin
                        m_phase = M_FIN;
                    end
                end
                M_RB: begin
                    if (m_rb == N) begin
                        m_phase = M_FIN;
                        m_err = (exp_read_xor() != m_wxor);
                    end else begin
                        m_rb++;
                        if (m_rb < N) e_addr = AW'((BASE + m_rb) % 64);
                    end
                end
                default: begin
                    m_phase = M_IDLE; m_fin_seen = 1'b1;
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs mid-cycle, then let the model see the clock edge.
    task automatic step();
        @(negedge clk);
        chk("cfg_ready_out", cfg_ready_out, (m_phase == M_LOAD && m_acc < N));
        chk("write_en", write_en, e_we);
        chk("addr", addr, e_addr);
        chk("wdata", wdata, e_wdata);
        chk("busy", busy, (m_phase != M_IDLE));
        chk("done", done, (m_phase == M_FIN));
        chk("err", err, m_err);
        if (write_en) begin
            if (addr == AW'(CADDR)) mon_ctrl++;
            else mon_coeff++;
        end
        if (done) begin
            mon_done++;
            mon_err = err;
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- scenario table ----------------
    // vmode: 0 valid high/inc data, 1 toggled valid/inc data,
    //        2 valid high/random data, 3 random valid/random data
    typedef struct {
        int vmode;
        int restart_at;
        int rst_at;
        bit corrupt;
        int exp_coeff;
        int exp_ctrl;
        int exp_done;
        bit exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic run_scn(input int idx, input vec_t v);
        logic [DW-1:0] words [N];
        bit start_pending = 1'b1;
        bit restart_done = 1'b0;
        bit reset_done = 1'b0;
        bit finished = 1'b0;
        for (int k = 0; k < N; k++)
            words[k] = (v.vmode <= 1) ? DW'(k + 1) : DW'($urandom);
        corrupt = v.corrupt;
        mon_coeff = 0; mon_ctrl = 0; mon_done = 0; mon_err = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            start = 1'b0;
            arst_n = 1'b1;
            cfg_valid_in = 1'($urandom_range(0, 1));
            cfg_data_in = DW'($urandom);
            if (m_phase == M_IDLE && start_pending) begin
                start = 1'b1; start_pending = 1'b0;
            end
            if (v.restart_at >= 0 && !restart_done && m_phase == M_LOAD && m_acc == v.restart_at) begin
                start = 1'b1; restart_done = 1'b1;
            end
            if (v.rst_at >= 0 && !reset_done && m_phase == M_LOAD && m_acc == v.rst_at && e_we) begin
                arst_n = 1'b0; reset_done = 1'b1; start_pending = 1'b1;
            end
            if (m_phase == M_LOAD && m_acc < N) begin
                case (v.vmode)
                    1:       cfg_valid_in = cyc[0];
                    3:       cfg_valid_in = ($urandom_range(0, 3) != 0);
                    default: cfg_valid_in = 1'b1;
                endcase
                cfg_data_in = words[m_acc];
            end
            step();
            if (m_fin_seen) finished = 1'b1;
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL timeout: scenario %0d did not complete, got busy=%0b expected idle", idx, busy);
        end
        start = 1'b0; arst_n = 1'b1;
        repeat (2) begin
            cfg_valid_in = 1'($urandom_range(0, 1));
            step();
        end
        chk("coeff_writes", mon_coeff, v.exp_coeff);
        chk("ctrl_writes", mon_ctrl, v.exp_ctrl);
        chk("done_pulses", mon_done, v.exp_done);
        chk("err_at_done", mon_err, v.exp_err);
        $display("scenario %0d: mode=%0d coeff_writes=%0d ctrl_writes=%0d dones=%0d err=%0b",
                 idx, v.vmode, mon_coeff, mon_ctrl, mon_done, mon_err);
    endtask

    initial begin
        vecs[0] = '{0, -1, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[1] = '{1, -1, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[2] = '{0,  5, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[3] = '{0, -1,  8, 1'b0, 24, 1, 1, 1'b0};
        vecs[4] = '{3, -1, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[5] = '{2, -1, -1, 1'b1, 16, 1, 1, RB};
        vecs[6] = '{3, -1, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[7] = '{2, -1, -1, 1'b0, 16, 1, 1, 1'b0};
        vecs[8] = '{3,  3, -1, 1'b0, 16, 1, 1, 1'b0};

        for (int a = 0; a < 64; a++) m_mem[a] = '0;
        arst_n = 1'b0; start = 1'b0; cfg_valid_in = 1'b0; cfg_data_in = '0; corrupt = 1'b0;
        mon_coeff = 0; mon_ctrl = 0; mon_done = 0; mon_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with stray start/valid that must be ignored.
        start = 1'b1; cfg_valid_in = 1'b1;
        step();
        step();
        start = 1'b0; cfg_valid_in = 1'b0; arst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_scn(i, vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
